// File: rtl/tile_renderer.sv
// Maps VGA pixel positions onto board cells and paints 2-bit RGB with syncs aligned.
// Latency: 2 clocks from px/py/syncs to rgb/syncs; no backpressure (one pixel per clock).
module tile_renderer #(
  parameter int TILE_SHIFT = 5,
  parameter int GRID_W     = 20,
  parameter int GRID_H     = 15,
  parameter int ADDR_W     = 9,
  parameter int V_DISPLAY  = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        px,
  input  logic [8:0]        py,
  input  logic              visible,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_data,
  output logic [1:0]        r,
  output logic [1:0]        g,
  output logic [1:0]        b,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_tick
);

  localparam int TILE = 1 << TILE_SHIFT;
  localparam logic [ADDR_W-1:0]     LP_GRID_W   = ADDR_W'(GRID_W);
  localparam logic [ADDR_W:0]       LP_CELLS    = (ADDR_W+1)'(GRID_W * GRID_H);
  localparam logic [8:0]            LP_VDISP    = 9'(V_DISPLAY);
  localparam logic [TILE_SHIFT-1:0] LP_APPLE_LO = TILE_SHIFT'(TILE / 4);
  localparam logic [TILE_SHIFT-1:0] LP_APPLE_HI = TILE_SHIFT'(3 * TILE / 4 - 1);

  localparam logic [1:0] CELL_BODY  = 2'd1;
  localparam logic [1:0] CELL_HEAD  = 2'd2;
  localparam logic [1:0] CELL_APPLE = 2'd3;

  logic [ADDR_W-1:0]     r_row_base;
  logic [ADDR_W-1:0]     r_rd_addr;
  logic                  r_vis1;
  logic                  r_hs1;
  logic                  r_vs1;
  logic [TILE_SHIFT-1:0] r_ox;
  logic [TILE_SHIFT-1:0] r_oy;
  logic [1:0]            r_r;
  logic [1:0]            r_g;
  logic [1:0]            r_b;
  logic                  r_hsync;
  logic                  r_vsync;
  logic                  r_frame_tick;

  logic                  w_in_display;
  logic                  w_frame_start;
  logic                  w_row_step;
  logic [ADDR_W-1:0]     w_row_base_next;
  logic [ADDR_W-1:0]     w_addr_next;
  logic                  w_gap_ok;
  logic                  w_core_ok;
  logic [1:0]            w_r;
  logic [1:0]            w_g;
  logic [1:0]            w_b;

  assign w_in_display  = (py < LP_VDISP);
  assign w_frame_start = (px == '0) && (py == '0);
  assign w_row_step    = (px == '0) && (py[TILE_SHIFT-1:0] == '0) && (py != '0) && w_in_display;

  // Row base steps by one grid row at each tile-row boundary instead of multiplying py.
  always_comb begin
    w_row_base_next = r_row_base;
    if (w_frame_start) begin
      w_row_base_next = '0;
    end else if (w_row_step) begin
      w_row_base_next = r_row_base + LP_GRID_W;
    end
  end

  assign w_addr_next = w_row_base_next + ADDR_W'(px[9:TILE_SHIFT]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_base   <= '0;
      r_rd_addr    <= '0;
      r_vis1       <= 1'b0;
      r_hs1        <= 1'b0;
      r_vs1        <= 1'b0;
      r_ox         <= '0;
      r_oy         <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_row_base <= w_row_base_next;
      if (visible && ({1'b0, w_addr_next} < LP_CELLS)) begin
        r_rd_addr <= w_addr_next;
      end
      r_vis1       <= visible && w_in_display;
      r_hs1        <= hsync_in;
      r_vs1        <= vsync_in;
      r_ox         <= px[TILE_SHIFT-1:0];
      r_oy         <= py[TILE_SHIFT-1:0];
      r_frame_tick <= (px == '0) && (py == LP_VDISP);
    end
  end

  // Snake segments leave a 1-px black border; apples fill only the tile's central half.
  assign w_gap_ok  = (r_ox != '0) && (r_ox != '1) && (r_oy != '0) && (r_oy != '1);
  assign w_core_ok = (r_ox >= LP_APPLE_LO) && (r_ox <= LP_APPLE_HI) &&
                     (r_oy >= LP_APPLE_LO) && (r_oy <= LP_APPLE_HI);

  always_comb begin
    w_r = 2'd0;
    w_g = 2'd0;
    w_b = 2'd0;
    if (r_vis1) begin
      case (rd_data)
        CELL_BODY: begin
          if (w_gap_ok) w_g = 2'd3;
        end
        CELL_HEAD: begin
          if (w_gap_ok) begin
            w_r = 2'd3;
            w_g = 2'd3;
          end
        end
        CELL_APPLE: begin
          if (w_core_ok) w_r = 2'd3;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r     <= '0;
      r_g     <= '0;
      r_b     <= '0;
      r_hsync <= 1'b0;
      r_vsync <= 1'b0;
    end else begin
      r_r     <= w_r;
      r_g     <= w_g;
      r_b     <= w_b;
      r_hsync <= r_hs1;
      r_vsync <= r_vs1;
    end
  end

  assign rd_addr    = r_rd_addr;
  assign r          = r_r;
  assign g          = r_g;
  assign b          = r_b;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign frame_tick = r_frame_tick;

endmodule
